// File: rtl/sync_filter.sv
// sync_filter: per-bit multi-flop synchronizer with an optional stability filter
// and registered rise/fall/change pulses for clock-domain entry points.
module sync_filter #(
  parameter int unsigned      WIDTH      = 1,
  parameter int unsigned      STAGES     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter int unsigned      FILTER     = 0,
  parameter bit               SIM_JITTER = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg
);

  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] q_next;

  (* ASYNC_REG = "TRUE", keep = "true", dont_touch = "true", shreg_extract = "no" *)
  logic [WIDTH-1:0] chain [STAGES];

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_filter: STAGES must be in 2..4, got %0d", STAGES);
  end

  // Jitter randomly lets the first flop take last cycle's d, mimicking a
  // metastable capture that resolves one cycle late; hardware always takes d.
  if (SIM_JITTER) begin : g_jitter
`ifndef SYNTHESIS
    logic [WIDTH-1:0] d_prev;
    logic [WIDTH-1:0] pick;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_prev <= RESET_VAL;
        pick   <= '0;
      end else begin
        d_prev <= d;
        pick   <= WIDTH'($urandom);
      end
    end

    assign cap = (d & ~pick) | (d_prev & pick);
`else
    assign cap = d;
`endif
  end else begin : g_no_jitter
    assign cap = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) chain[k] <= RESET_VAL;
    end else begin
      chain[0] <= cap;
      for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
    end
  end

  assign s = chain[STAGES-1];

  if (FILTER == 0) begin : g_no_filter
    assign q_next = s;
  end else begin : g_filter
    localparam int unsigned     CW   = $clog2(FILTER + 1);
    localparam logic [CW-1:0]   LAST = CW'(FILTER - 1);

    logic [CW-1:0] cnt      [WIDTH];
    logic [CW-1:0] cnt_next [WIDTH];

    // A bit's counter measures how long the synced value has disagreed with q;
    // any agreement (including q catching up) restarts it from zero.
    always_comb begin
      q_next = q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_next[i] = '0;
        if (s[i] != q[i]) begin
          if (cnt[i] == LAST) begin
            q_next[i] = s[i];
          end else begin
            cnt_next[i] = cnt[i] + CW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
      end
    end
  end

  // Edge pulses are registered alongside q so they coincide with its first new cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      chg  <= 1'b0;
    end else begin
      q    <= q_next;
      rise <= q_next & ~q;
      fall <= ~q_next & q;
      chg  <= |(q_next ^ q);
    end
  end

endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: random and directed stimulus for several sync_filter configurations,
// checked every cycle against a sliding-window history model of d.
module tb_sync_filter;

  localparam int         HD   = 16;
  localparam logic [3:0] RV_B = 4'b0110;
  localparam logic [7:0] RV_C = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] d_a;
  logic [3:0] d_b;
  logic [7:0] d_c;
  logic [3:0] d_j;

  logic [0:0] q_a, rise_a, fall_a;
  logic [3:0] q_b, rise_b, fall_b;
  logic [7:0] q_c, rise_c, fall_c;
  logic [3:0] q_j, rise_j, fall_j;
  logic       chg_a, chg_b, chg_c, chg_j;

  int n_vec   = 0;
  int n_err   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  sync_filter #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0), .FILTER(0), .SIM_JITTER(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .d(d_a), .q(q_a), .rise(rise_a), .fall(fall_a), .chg(chg_a));

  sync_filter #(.WIDTH(4), .STAGES(3), .RESET_VAL(RV_B), .FILTER(4), .SIM_JITTER(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .d(d_b), .q(q_b), .rise(rise_b), .fall(fall_b), .chg(chg_b));

  sync_filter #(.WIDTH(8), .STAGES(2), .RESET_VAL(RV_C), .FILTER(0), .SIM_JITTER(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .d(d_c), .q(q_c), .rise(rise_c), .fall(fall_c), .chg(chg_c));

  sync_filter #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'h0), .FILTER(2), .SIM_JITTER(1'b1)) u_j (
    .clk(clk), .rst_n(rst_n), .d(d_j), .q(q_j), .rise(rise_j), .fall(fall_j), .chg(chg_j));

  // History h holds d as seen at successive edges, newest in the low byte. The value the
  // output stage sees at an edge is d from STAGES edges earlier; a bit flips once that
  // delayed value has disagreed with q on each of the last FILTER edges.
  function automatic logic [7:0] model_q(input logic [8*HD-1:0] h, input int stages,
                                         input int filt, input logic [7:0] qp);
    logic [7:0] r;
    bit         all_diff;
    if (filt == 0) return h[8*stages +: 8];
    r = qp;
    for (int b = 0; b < 8; b++) begin
      all_diff = 1'b1;
      for (int m = 0; m < filt; m++)
        if (h[8*(m+stages) + b] == qp[b]) all_diff = 1'b0;
      if (all_diff) r[b] = ~qp[b];
    end
    return r;
  endfunction

  logic [8*HD-1:0] ha, hb, hc, na, nb, nc;
  logic [7:0]      mqa, mra, mfa, mqb, mrb, mfb, mqc, mrc, mfc;
  logic [7:0]      nqa, nqb, nqc;

  assign na  = {ha[8*HD-9:0], 7'b0, d_a};
  assign nb  = {hb[8*HD-9:0], 4'b0, d_b};
  assign nc  = {hc[8*HD-9:0], d_c};
  assign nqa = model_q(na, 2, 0, mqa);
  assign nqb = model_q(nb, 3, 4, mqb);
  assign nqc = model_q(nc, 2, 0, mqc);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ha <= '0;                   mqa <= 8'h00;          mra <= '0; mfa <= '0;
      hb <= {HD{{4'b0, RV_B}}};   mqb <= {4'b0, RV_B};   mrb <= '0; mfb <= '0;
      hc <= {HD{RV_C}};           mqc <= RV_C;           mrc <= '0; mfc <= '0;
    end else begin
      ha <= na; mqa <= nqa; mra <= nqa & ~mqa; mfa <= ~nqa & mqa;
      hb <= nb; mqb <= nqb; mrb <= nqb & ~mqb; mfb <= ~nqb & mqb;
      hc <= nc; mqc <= nqc; mrc <= nqc & ~mqc; mfc <= ~nqc & mqc;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Jittered instance: only settled level and pulse/transition bookkeeping are checked.
  logic [3:0] prev_qj   = 4'h0;
  bit         prev_rst  = 1'b0;
  int         n_pulse   = 0;
  int         n_trans   = 0;
  int         since_rst = 0;

  always @(posedge clk) since_rst <= rst_n ? since_rst + 1 : 0;

  always @(negedge clk) begin
    if (started) begin
      check_output("cyc_a", 32'({q_a, rise_a, fall_a, chg_a}),
                   32'({mqa[0], mra[0], mfa[0], |(mra | mfa)}));
      check_output("cyc_b", 32'({q_b, rise_b, fall_b, chg_b}),
                   32'({mqb[3:0], mrb[3:0], mfb[3:0], |(mrb | mfb)}));
      check_output("cyc_c", 32'({q_c, rise_c, fall_c, chg_c}),
                   32'({mqc, mrc, mfc, |(mrc | mfc)}));
      if (rst_n && prev_rst) begin
        n_pulse <= n_pulse + $countones(rise_j | fall_j);
        n_trans <= n_trans + $countones(q_j ^ prev_qj);
      end
    end
    prev_qj  <= q_j;
    prev_rst <= rst_n;
  end

  initial begin
    wait (started);
    forever begin
      edge_wait(12);
      if (rst_n && since_rst >= 12) check_output("jit_settle", 32'(q_j), 32'(d_j));
      d_j = 4'($urandom);
    end
  end

  task automatic apply_stimulus(input int cycles);
    for (int t = 0; t < cycles; t++) begin
      if ($urandom_range(0, 3) == 0) d_a = ~d_a;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) d_b[b] = ~d_b[b];
      if ($urandom_range(0, 3) == 0) d_c = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        edge_wait(2);
        rst_n = 1'b1;
      end
      edge_wait(1);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    d_a   = 1'b0;
    d_b   = RV_B;
    d_c   = RV_C;
    d_j   = 4'h0;
    #1 rst_n = 1'b0;
    started = 1'b1;
    edge_wait(3);
    rst_n = 1'b1;

    check_output("reset_q_a", 32'(q_a), 32'h0);
    check_output("reset_q_b", 32'(q_b), 32'h6);
    check_output("reset_c", 32'({q_c, rise_c, fall_c, chg_c}), 32'({8'hA5, 8'h00, 8'h00, 1'b0}));

    // Single-bit and wide unfiltered paths: q appears STAGES+1 edges after d.
    d_a = 1'b1;
    d_c = 8'h5A;
    edge_wait(2);
    check_output("lat_a_early", 32'(q_a), 32'h0);
    edge_wait(1);
    check_output("lat_a_rise", 32'({q_a, rise_a, fall_a, chg_a}), 32'({1'b1, 1'b1, 1'b0, 1'b1}));
    check_output("wide_c_edge", 32'({q_c, rise_c, fall_c, chg_c}), 32'({8'h5A, 8'h5A, 8'hA5, 1'b1}));
    edge_wait(1);
    check_output("pulse_a_once", 32'({rise_a, chg_a}), 32'h0);
    check_output("pulse_c_once", 32'({rise_c, fall_c, chg_c}), 32'h0);

    // Pulse shorter than the filter is rejected, then a held level passes after 3+4.
    d_b = 4'b0111;
    edge_wait(3);
    d_b = RV_B;
    edge_wait(10);
    check_output("short_pulse_b", 32'(q_b), 32'h6);
    d_b = 4'b0111;
    edge_wait(6);
    check_output("filt_b_early", 32'(q_b), 32'h6);
    edge_wait(1);
    check_output("filt_b_rise", 32'({q_b, rise_b, fall_b, chg_b}), 32'({4'h7, 4'h1, 4'h0, 1'b1}));

    // One-cycle glitch mid-count restarts the filter window.
    d_b = 4'b1111;
    edge_wait(2);
    d_b = 4'b0111;
    edge_wait(1);
    d_b = 4'b1111;
    edge_wait(6);
    check_output("glitch_b_hold", 32'(q_b), 32'h7);
    edge_wait(1);
    check_output("glitch_b_rise", 32'({q_b, rise_b}), 32'({4'hF, 4'h8}));

    // Reset while bit 0 is two edges into its count.
    d_b = 4'b1110;
    edge_wait(5);
    #1 rst_n = 1'b0;
    #1 check_output("async_rst_b", 32'({q_b, rise_b, fall_b, chg_b}), 32'({RV_B, 4'h0, 4'h0, 1'b0}));
    edge_wait(1);
    rst_n = 1'b1;
    edge_wait(6);
    check_output("post_rst_b_hold", 32'({q_b, chg_b}), 32'({RV_B, 1'b0}));
    edge_wait(1);
    check_output("post_rst_b_rise", 32'({q_b, rise_b, fall_b}), 32'({4'hE, 4'h8, 4'h0}));

    apply_stimulus(1500);

    check_output("jit_pulse_count", 32'(n_pulse), 32'(n_trans));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
